// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: registered MIPS-subset control decoder.
// Main control (opcode -> datapath strobes + ALU-op class) and ALU control
// (ALU-op class + funct -> ALU select) are decoded in parallel from their own
// inputs and registered together, so every output has one cycle of latency.
module mips_ctrl_decode #(
    parameter int OPW = 6,
    parameter int ACW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] instr_op,
    input  logic [1:0]     alu_op_in,
    input  logic [OPW-1:0] instruction_5_0,
    output logic           reg_dst,
    output logic           alu_src,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           branch,
    output logic [1:0]     alu_op,
    output logic [ACW-1:0] alu_out,
    output logic           illegal_op
);

    // Supported opcodes
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;

    // ALU-op classes
    localparam logic [1:0] AOP_ADD = 2'b00;
    localparam logic [1:0] AOP_SUB = 2'b01;
    localparam logic [1:0] AOP_FN  = 2'b10;

    // ALU operation selects
    localparam logic [ACW-1:0] ALU_AND = 4'b0000;
    localparam logic [ACW-1:0] ALU_OR  = 4'b0001;
    localparam logic [ACW-1:0] ALU_ADD = 4'b0010;
    localparam logic [ACW-1:0] ALU_SUB = 4'b0110;
    localparam logic [ACW-1:0] ALU_SLT = 4'b0111;
    localparam logic [ACW-1:0] ALU_NOR = 4'b1100;

    // Bundled main-control word so decode and register stay in lockstep
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    ctrl_t          w_ctrl;
    logic [ACW-1:0] w_alu_sel;
    ctrl_t          r_ctrl;
    logic [ACW-1:0] r_alu_sel;

    // Main control: unrecognised opcodes leave every strobe low and flag illegal
    always_comb begin
        w_ctrl            = '0;
        w_ctrl.alu_op     = AOP_ADD;
        w_ctrl.illegal_op = 1'b0;
        unique case (instr_op)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = AOP_FN;
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = AOP_SUB;
            end
            default: begin
                w_ctrl.illegal_op = 1'b1;
            end
        endcase
    end

    // ALU control: class bit 1 wins (so 11 still decodes funct); funct[5:4] ignored
    always_comb begin
        w_alu_sel = ALU_ADD;
        if (alu_op_in[1]) begin
            case (instruction_5_0[3:0])
                4'b0000: w_alu_sel = ALU_ADD;
                4'b0010: w_alu_sel = ALU_SUB;
                4'b0100: w_alu_sel = ALU_AND;
                4'b0101: w_alu_sel = ALU_OR;
                4'b0111: w_alu_sel = ALU_NOR;
                4'b1010: w_alu_sel = ALU_SLT;
                default: w_alu_sel = ALU_ADD;
            endcase
        end else if (alu_op_in[0]) begin
            w_alu_sel = ALU_SUB;
        end else begin
            w_alu_sel = ALU_ADD;
        end
    end

    // Output register; synchronous reset clears everything including illegal_op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_alu_sel <= '0;
        end else begin
            r_ctrl    <= w_ctrl;
            r_alu_sel <= w_alu_sel;
        end
    end

    assign reg_dst    = r_ctrl.reg_dst;
    assign alu_src    = r_ctrl.alu_src;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign branch     = r_ctrl.branch;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal_op = r_ctrl.illegal_op;
    assign alu_out    = r_alu_sel;

endmodule

// File: tb/tb_mips_ctrl_decode.sv
// Scoreboard bench for mips_ctrl_decode: stimulus pushes the expected output
// word for each issued cycle; a monitor pops and compares after every edge.
module tb_mips_ctrl_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instr_op;
    logic [1:0] alu_op_in;
    logic [5:0] instruction_5_0;
    logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0] alu_op;
    logic [3:0] alu_out;
    logic       illegal_op;

    always #5 clk = ~clk;

    mips_ctrl_decode #(.OPW(6), .ACW(4)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .alu_op_in(alu_op_in),
        .instruction_5_0(instruction_5_0),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .alu_op(alu_op), .alu_out(alu_out), .illegal_op(illegal_op)
    );

    // Expected word: {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op[1:0],alu_out[3:0],illegal}
    typedef struct {
        logic [13:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    logic [3:0] funct_tbl [16];

    // Reference model: opcode table lookup plus funct table
    function automatic logic [13:0] model(input logic r, input logic [5:0] op,
                                          input logic [1:0] aop, input logic [5:0] fn);
        logic [8:0] c;
        logic       ill;
        logic [3:0] a;
        if (r) return 14'd0;
        ill = 1'b0;
        if      (op == 6'd0)  c = 9'b1001000_10;
        else if (op == 6'd35) c = 9'b0111100_00;
        else if (op == 6'd43) c = 9'b0100010_00;
        else if (op == 6'd4)  c = 9'b0000001_01;
        else begin c = 9'd0; ill = 1'b1; end
        if (aop >= 2'd2)      a = funct_tbl[fn[3:0]];
        else if (aop == 2'd1) a = 4'd6;
        else                  a = 4'd2;
        return {c, a, ill};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [1:0] aop,
                        input logic [5:0] fn, input string name);
        sb_t e;
        @(negedge clk);
        rst = r; instr_op = op; alu_op_in = aop; instruction_5_0 = fn;
        e.exp  = model(r, op, aop, fn);
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: each edge retires exactly the one cycle issued just before it
    initial begin
        sb_t e;
        logic [13:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                       branch, alu_op, alu_out, illegal_op};
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        logic [5:0] op, fn;
        logic [1:0] aop;
        logic       r;
        int         sel;
        int         budget;
        for (int i = 0; i < 16; i++) funct_tbl[i] = 4'b0010;
        funct_tbl[0]  = 4'b0010;
        funct_tbl[2]  = 4'b0110;
        funct_tbl[4]  = 4'b0000;
        funct_tbl[5]  = 4'b0001;
        funct_tbl[7]  = 4'b1100;
        funct_tbl[10] = 4'b0111;
        rst = 1'b1; instr_op = '0; alu_op_in = '0; instruction_5_0 = '0;

        // Reset, main decode, ALU decode, mid-stream reset
        step(1, 6'b000000, 2'b00, 6'b000000, "reset0");
        step(1, 6'b000000, 2'b00, 6'b000000, "reset1");
        step(0, 6'b000000, 2'b10, 6'b100000, "rtype");
        step(0, 6'b101011, 2'b00, 6'b000000, "sw");
        step(0, 6'b100011, 2'b00, 6'b000000, "lw");
        step(0, 6'b000100, 2'b01, 6'b000000, "beq");
        step(0, 6'b001111, 2'b00, 6'b000000, "illegal");
        step(0, 6'b000000, 2'b00, 6'b101010, "alu00");
        step(0, 6'b000000, 2'b01, 6'b101010, "alu01");
        step(0, 6'b000000, 2'b11, 6'b110000, "alu11_fn");
        step(0, 6'b000000, 2'b11, 6'b100010, "alu11_sub_fn");
        step(0, 6'b000000, 2'b10, 6'b100010, "fn_sub");
        step(0, 6'b000000, 2'b10, 6'b100100, "fn_and");
        step(0, 6'b000000, 2'b10, 6'b100101, "fn_or");
        step(0, 6'b000000, 2'b10, 6'b100111, "fn_nor");
        step(0, 6'b000000, 2'b10, 6'b101010, "fn_slt");
        step(0, 6'b000000, 2'b10, 6'b111111, "fn_default");
        step(0, 6'b000000, 2'b10, 6'b010101, "fn_hi_ignored");
        step(0, 6'b101011, 2'b00, 6'b000000, "sw_pre");
        step(1, 6'b101011, 2'b10, 6'b100100, "mid_reset");
        step(0, 6'b101011, 2'b00, 6'b000000, "sw_post");

        // Randomised: legal opcodes favoured, occasional reset
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    op = 6'b000000;
                2:       op = 6'b100011;
                3:       op = 6'b101011;
                4:       op = 6'b000100;
                default: op = 6'($urandom);
            endcase
            aop = 2'($urandom);
            fn  = 6'($urandom);
            r   = ($urandom_range(0, 19) == 0);
            step(r, op, aop, fn, "random");
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
